// File: rtl/conv2_pool_2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv2_pool_2_pkg
// Description : Shared constants for the conv2 post-processing stages:
//               default sample/result widths, map size and the per-channel
//               bias values applied before ReLU.
// Revision    : 1.0 - initial release
// ============================================================================
package conv2_pool_2_pkg;

    localparam int c_conv2_in_w  = 14;   // signed conv2 MAC output width
    localparam int c_conv2_out_w = 12;   // unsigned pooled result width
    localparam int c_conv2_map_w = 8;    // conv2 map is 8x8

    // Per-output-channel bias, signed, same width as the conv sample.
    localparam logic signed [c_conv2_in_w-1:0] c_conv2_bias_ch0 = 14'sd0;
    localparam logic signed [c_conv2_in_w-1:0] c_conv2_bias_ch1 = 14'sd0;
    localparam logic signed [c_conv2_in_w-1:0] c_conv2_bias_ch2 = 14'sd0;
    localparam logic signed [c_conv2_in_w-1:0] c_conv2_bias_ch3 = 14'sd0;

endpackage
`default_nettype wire

// File: rtl/conv2_pool_2_if.sv
`default_nettype none
// ============================================================================
// Module      : conv2_pool_2_if
// Description : Streaming interface of the conv2 pool stage.
//               valid_in   - data_in carries a map sample this cycle
//               data_in    - signed conv2 sample, raster order
//               data_out   - pooled result (holds between strobes)
//               valid_out  - one-cycle strobe, data_out valid
//               frame_done - strobe coincident with the last result of a map
//               Modport slave is the pool stage, master is its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv2_pool_2_if
    import conv2_pool_2_pkg::*;
#(
    parameter int IN_W  = c_conv2_in_w,
    parameter int OUT_W = c_conv2_out_w
) ();

    logic                    valid_in;
    logic signed [IN_W-1:0]  data_in;
    logic [OUT_W-1:0]        data_out;
    logic                    valid_out;
    logic                    frame_done;

    modport master (
        output valid_in,
        output data_in,
        input  data_out,
        input  valid_out,
        input  frame_done
    );

    modport slave (
        input  valid_in,
        input  data_in,
        output data_out,
        output valid_out,
        output frame_done
    );

endinterface
`default_nettype wire

// File: rtl/conv2_pool_2_bias_relu.sv
`default_nettype none
// ============================================================================
// Module      : conv2_pool_2_bias_relu
// Description : Combinational bias add, ReLU and output range reduction.
//               Ports: data_in  - signed IN_W conv sample
//                      data_out - unsigned OUT_W activation
//               Build macro CONV2_POOL_SAT_EN: when defined, positive values
//               above 2^OUT_W-1 clamp to 2^OUT_W-1; otherwise they keep only
//               their low OUT_W bits (wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module conv2_pool_2_bias_relu
    import conv2_pool_2_pkg::*;
#(
    parameter int                      IN_W  = c_conv2_in_w,
    parameter int                      OUT_W = c_conv2_out_w,
    parameter logic signed [IN_W-1:0]  BIAS  = c_conv2_bias_ch2
) (
    input  wire logic signed [IN_W-1:0] data_in,
    output logic [OUT_W-1:0]            data_out
);

    // One extra bit of headroom: the sum of two IN_W signed values cannot
    // overflow IN_W+1 bits.
    logic signed [IN_W:0] w_sum;

    assign w_sum = {data_in[IN_W-1], data_in} + {BIAS[IN_W-1], BIAS};

`ifdef CONV2_POOL_SAT_EN
    always_comb begin
        data_out = '0;
        if (w_sum[IN_W]) begin
            data_out = '0;
        end else if (w_sum[IN_W-1:OUT_W] != '0) begin
            data_out = '1;
        end else begin
            data_out = w_sum[OUT_W-1:0];
        end
    end
`else
    // Upper bits are intentionally discarded in the wrapping build.
    logic w_unused_hi;
    assign w_unused_hi = ^w_sum[IN_W-1:OUT_W];

    always_comb begin
        data_out = '0;
        if (!w_sum[IN_W]) begin
            data_out = w_sum[OUT_W-1:0];
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/conv2_pool_2.sv
`default_nettype none
// ============================================================================
// Module      : conv2_pool_2
// Description : conv2 output-channel-2 post-processing: bias + ReLU +
//               saturation/wrap, then streaming 2x2 stride-2 max-pool of an
//               MAP_W x MAP_W raster map into (MAP_W/2)^2 results.
//               Ports: clk  - clock, rising edge
//                      rst  - synchronous active-low reset
//                      bus  - conv2_pool_2_if.slave (valid_in, data_in,
//                             data_out, valid_out, frame_done)
//               Build macro CONV2_POOL_SAT_EN selects clamping instead of
//               wrapping for activations above 2^OUT_W-1.
// Revision    : 1.0 - initial release
// ============================================================================
module conv2_pool_2
    import conv2_pool_2_pkg::*;
#(
    parameter int                      IN_W  = c_conv2_in_w,
    parameter int                      OUT_W = c_conv2_out_w,
    parameter int                      MAP_W = c_conv2_map_w,
    parameter logic signed [IN_W-1:0]  BIAS  = c_conv2_bias_ch2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    conv2_pool_2_if.slave    bus
);

    localparam int                c_cw   = $clog2(MAP_W);
    localparam int                c_lb_n = MAP_W / 2;
    localparam logic [c_cw-1:0]   c_last = c_cw'(MAP_W - 1);

    logic [c_cw-1:0]   r_col;
    logic [c_cw-1:0]   r_row;
    logic [OUT_W-1:0]  r_hold;
    logic [OUT_W-1:0]  r_lb [c_lb_n];
    logic [OUT_W-1:0]  r_data_out;
    logic              r_valid_out;
    logic              r_frame_done;

    logic [OUT_W-1:0]  w_act;
    logic [OUT_W-1:0]  w_pair;
    logic [OUT_W-1:0]  w_pool;
    logic [c_cw-2:0]   w_lb_idx;

    conv2_pool_2_bias_relu #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .BIAS  (BIAS)
    ) u_bias_relu (
        .data_in  (bus.data_in),
        .data_out (w_act)
    );

    // Each line-buffer slot covers one horizontal pair of columns.
    assign w_lb_idx = r_col[c_cw-1:1];
    // Horizontal max of the current pair (meaningful on odd columns).
    assign w_pair   = (r_hold > w_act) ? r_hold : w_act;
    // Vertical max against the pair stored from the even row above.
    assign w_pool   = (r_lb[w_lb_idx] > w_pair) ? r_lb[w_lb_idx] : w_pair;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_hold       <= '0;
            r_data_out   <= '0;
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < c_lb_n; i++) begin
                r_lb[i] <= '0;
            end
        end else begin
            // Strobes default low; only an emitting sample raises them.
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;

            if (bus.valid_in) begin
                if (r_col == c_last) begin
                    r_col <= '0;
                    r_row <= (r_row == c_last) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end

                if (!r_col[0]) begin
                    r_hold <= w_act;
                end else if (!r_row[0]) begin
                    r_lb[w_lb_idx] <= w_pair;
                end else begin
                    r_data_out   <= w_pool;
                    r_valid_out  <= 1'b1;
                    r_frame_done <= (r_row == c_last) && (r_col == c_last);
                end
            end
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.valid_out  = r_valid_out;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_conv2_pool_2.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv2_pool_2
// Description : Self-checking bench for conv2_pool_2. Two instances: dut0
//               with BIAS=0 and dut1 with BIAS=-10. A table of map tests is
//               applied and each collected result stream is compared against
//               hand-derived values; reset and mid-map reset are hand-written
//               sequences. Honours CONV2_POOL_SAT_EN for saturation values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2_pool_2;

    localparam int IN_W  = 14;
    localparam int OUT_W = 12;

`ifdef CONV2_POOL_SAT_EN
    localparam int SAT_EXP = 4095;
`else
    localparam int SAT_EXP = 904;    // 5000 mod 4096
`endif

    localparam int M_RAMP  = 0;      // sample = 8*row + col
    localparam int M_CONST = 1;      // sample = a
    localparam int M_ALT   = 2;      // even col a, odd col b

    typedef struct {
        string name;
        int    dut;
        int    mode;
        int    a;
        int    b;
        int    gap;
        int    nmaps;
        bit    exp_ramp;
        int    exp_val;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                   vi  [2];
    logic signed [IN_W-1:0] din [2];

    conv2_pool_2_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus0 ();
    conv2_pool_2_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus1 ();

    assign bus0.valid_in = vi[0];
    assign bus0.data_in  = din[0];
    assign bus1.valid_in = vi[1];
    assign bus1.data_in  = din[1];

    conv2_pool_2 #(.IN_W(IN_W), .OUT_W(OUT_W), .MAP_W(8), .BIAS(14'sd0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    conv2_pool_2 #(.IN_W(IN_W), .OUT_W(OUT_W), .MAP_W(8), .BIAS(-14'sd10)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [12:0] q0 [$];
    logic [12:0] q1 [$];
    int          stray_fd = 0;
    bit          consec0  = 1'b0;
    bit          prev0    = 1'b0;

    // Collect every strobe as {frame_done, data_out}, away from the edge.
    always @(negedge clk) begin
        if (bus0.valid_out) q0.push_back({bus0.frame_done, bus0.data_out});
        if (bus1.valid_out) q1.push_back({bus1.frame_done, bus1.data_out});
        if (bus0.frame_done && !bus0.valid_out) stray_fd++;
        if (bus1.frame_done && !bus1.valid_out) stray_fd++;
        if (bus0.valid_out && prev0) consec0 = 1'b1;
        prev0 = bus0.valid_out;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    function automatic int sample(input int mode, input int a, input int b,
                                  input int r, input int c);
        if (mode == M_RAMP)  return 8 * r + c;
        if (mode == M_CONST) return a;
        return (c % 2 == 0) ? a : b;
    endfunction

    task automatic drive_map(input int d, input int mode, input int a, input int b,
                             input int gap, input int nmaps);
        for (int m = 0; m < nmaps; m++) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    vi[d]  = 1'b1;
                    din[d] = IN_W'(sample(mode, a, b, r, c));
                    @(posedge clk); #1;
                    for (int g = 0; g < gap; g++) begin
                        vi[d] = 1'b0;
                        @(posedge clk); #1;
                    end
                end
            end
        end
        vi[d] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_map(input string nm, input int d, input int nmaps,
                             input bit ramp, input int val);
        int          n;
        int          exp_d;
        logic [12:0] e;
        n = (d == 0) ? q0.size() : q1.size();
        chk({nm, " count"}, 32'(n), 32'(16 * nmaps));
        for (int k = 0; k < n && k < 16 * nmaps; k++) begin
            e     = (d == 0) ? q0[k] : q1[k];
            exp_d = ramp ? 16 * ((k % 16) / 4) + 2 * (k % 4) + 9 : val;
            chk({nm, " data"}, 32'(e[11:0]), 32'(exp_d));
            chk({nm, " frame_done"}, 32'(e[12]), 32'(k % 16 == 15));
        end
        // data_out holds the last result once the strobes stop.
        exp_d = ramp ? 63 : val;
        chk({nm, " hold"}, 32'((d == 0) ? bus0.data_out : bus1.data_out), 32'(exp_d));
        chk({nm, " idle valid"}, 32'((d == 0) ? bus0.valid_out : bus1.valid_out), 32'd0);
    endtask

    vec_t tbl [7];

    initial begin
        tbl[0] = '{"ramp",       0, M_RAMP,  0,    0,    0, 1, 1'b1, 0};
        tbl[1] = '{"ramp_b2b",   0, M_RAMP,  0,    0,    0, 2, 1'b1, 0};
        tbl[2] = '{"relu_zero",  1, M_ALT,   5,    -200, 0, 1, 1'b0, 0};
        tbl[3] = '{"relu_pos",   1, M_CONST, 30,   0,    0, 1, 1'b0, 20};
        tbl[4] = '{"saturate",   0, M_CONST, 5000, 0,    0, 1, 1'b0, SAT_EXP};
        tbl[5] = '{"bubbles",    0, M_RAMP,  0,    0,    1, 1, 1'b1, 0};
        tbl[6] = '{"mixed_max",  0, M_ALT,   5,    -200, 0, 1, 1'b0, 5};

        // Reset held with valid_in high: all outputs must stay at zero.
        vi[0] = 1'b1; vi[1] = 1'b1;
        din[0] = 14'sd123; din[1] = 14'sd123;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("reset valid_out0", 32'(bus0.valid_out), 32'd0);
            chk("reset frame_done0", 32'(bus0.frame_done), 32'd0);
            chk("reset data_out0", 32'(bus0.data_out), 32'd0);
            chk("reset valid_out1", 32'(bus1.valid_out), 32'd0);
            chk("reset data_out1", 32'(bus1.data_out), 32'd0);
        end
        vi[0] = 1'b0; vi[1] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        q0.delete(); q1.delete();

        for (int t = 0; t < 7; t++) begin
            q0.delete(); q1.delete();
            consec0 = 1'b0;
            drive_map(tbl[t].dut, tbl[t].mode, tbl[t].a, tbl[t].b, tbl[t].gap, tbl[t].nmaps);
            check_map(tbl[t].name, tbl[t].dut, tbl[t].nmaps, tbl[t].exp_ramp, tbl[t].exp_val);
            if (tbl[t].gap > 0) chk({tbl[t].name, " back-to-back strobes"}, 32'(consec0), 32'd0);
        end

        // Mid-map reset: 20 ramp samples yield the first block row only.
        q0.delete();
        for (int s = 0; s < 20; s++) begin
            vi[0]  = 1'b1;
            din[0] = IN_W'(s);
            @(posedge clk); #1;
        end
        vi[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("partial count", 32'(q0.size()), 32'd4);
        for (int k = 0; k < q0.size() && k < 4; k++) begin
            chk("partial data", 32'(q0[k][11:0]), 32'(9 + 2 * k));
        end
        q0.delete();
        rst    = 1'b0;
        vi[0]  = 1'b1;
        din[0] = 14'sd99;
        @(posedge clk); #1;
        rst   = 1'b1;
        vi[0] = 1'b0;
        drive_map(0, M_RAMP, 0, 0, 0, 1);
        check_map("after_reset", 0, 1, 1'b1, 0);

        chk("stray frame_done", 32'(stray_fd), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
